// File: rtl/sound_arbiter_pkg.sv
// Shared sound types, source enum, default durations and the source-to-sound map
// used by the playback arbiter.
package sound_arbiter_pkg;

  typedef enum logic [2:0] {
    SOUND_NONE  = 3'd0,
    SOUND_CHOMP = 3'd1,
    SOUND_FRUIT = 3'd2,
    SOUND_POWER = 3'd3,
    SOUND_DEATH = 3'd4
  } sound_t;

  // Source index doubles as priority: a higher value preempts a lower one.
  typedef enum logic [1:0] {
    SRC_CHOMP = 2'd0,
    SRC_FRUIT = 2'd1,
    SRC_POWER = 2'd2,
    SRC_DEATH = 2'd3
  } sound_src_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam int DEF_DUR_CHOMP = 2000;
  localparam int DEF_DUR_FRUIT = 4000;
  localparam int DEF_DUR_POWER = 8000;
  localparam int DEF_DUR_DEATH = 12000;
  localparam int DEF_GAP_TICKS = 80;

  function automatic sound_t src_to_sound(input sound_src_t src);
    case (src)
      SRC_CHOMP: return SOUND_CHOMP;
      SRC_FRUIT: return SOUND_FRUIT;
      SRC_POWER: return SOUND_POWER;
      SRC_DEATH: return SOUND_DEATH;
      default:   return SOUND_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sound_arbiter_prio_enc.sv
// 4-to-2 highest-set-bit encoder with a valid flag; bit 3 has top priority.
module sound_prio_enc
  import sound_arbiter_pkg::*;
(
  input  logic [3:0] vec,
  output logic       valid,
  output sound_src_t idx
);

  always_comb begin
    valid = |vec;
    idx   = SRC_CHOMP;
    if (vec[3])      idx = SRC_DEATH;
    else if (vec[2]) idx = SRC_POWER;
    else if (vec[1]) idx = SRC_FRUIT;
  end

endmodule

// File: rtl/sound_arbiter.sv
// Shares the single audio channel between the game sound requesters: fixed
// priority with preemption, a pending queue for lower requests, tick-timed play/gap.
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int DUR_CHOMP = DEF_DUR_CHOMP,
  parameter int DUR_FRUIT = DEF_DUR_FRUIT,
  parameter int DUR_POWER = DEF_DUR_POWER,
  parameter int DUR_DEATH = DEF_DUR_DEATH,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_8khz,
  input  logic [3:0] req,
  input  logic       mute,
  output sound_t     sound_type,
  output logic       busy,
  output logic [1:0] active_src,
  output logic       done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  arb_state_t           state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic [3:0]           pending, pending_d, merged;
  sound_src_t           src, src_d;
  logic                 done_d;
  logic                 req_valid, pend_valid;
  sound_src_t           req_idx, pend_idx;

  // Requests arriving this cycle are folded into the queue before it is encoded.
  assign merged = pending | req;

  sound_prio_enc u_req_enc (.vec(req),    .valid(req_valid),  .idx(req_idx));
  sound_prio_enc u_pend_enc(.vec(merged), .valid(pend_valid), .idx(pend_idx));

  function automatic logic [CNT_WIDTH-1:0] dur_of(input sound_src_t s);
    case (s)
      SRC_CHOMP: return CNT_WIDTH'(DUR_CHOMP);
      SRC_FRUIT: return CNT_WIDTH'(DUR_FRUIT);
      SRC_POWER: return CNT_WIDTH'(DUR_POWER);
      default:   return CNT_WIDTH'(DUR_DEATH);
    endcase
  endfunction

  function automatic logic [3:0] bit_of(input sound_src_t s);
    return 4'b0001 << s;
  endfunction

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pending_d = pending;
    src_d     = src;
    done_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_PLAY;
          src_d     = req_idx;
          cnt_d     = dur_of(req_idx);
          pending_d = merged & ~bit_of(req_idx);
        end
      end
      // Retrigger or preempt reloads and swallows a coinciding tick; the
      // preempted source is simply dropped.
      ST_PLAY: begin
        if (req_valid && (req_idx >= src)) begin
          src_d     = req_idx;
          cnt_d     = dur_of(req_idx);
          pending_d = merged & ~bit_of(req_idx);
        end else begin
          pending_d = merged;
          if (tick_8khz) begin
            if (cnt <= CNT_ONE) begin
              state_d = ST_GAP;
              cnt_d   = CNT_WIDTH'(GAP_TICKS);
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt - CNT_ONE;
            end
          end
        end
      end
      ST_GAP: begin
        pending_d = merged;
        if (tick_8khz) begin
          if (cnt <= CNT_ONE) begin
            if (pend_valid) begin
              state_d   = ST_PLAY;
              src_d     = pend_idx;
              cnt_d     = dur_of(pend_idx);
              pending_d = merged & ~bit_of(pend_idx);
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt - CNT_ONE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        pending_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so a request shows up
  // in the cycle right after the edge that sampled it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= '0;
      src        <= SRC_CHOMP;
      sound_type <= SOUND_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pending    <= pending_d;
      src        <= src_d;
      busy       <= (state_d != ST_IDLE);
      done       <= done_d;
      sound_type <= (state_d == ST_PLAY && !mute) ? src_to_sound(src_d) : SOUND_NONE;
    end
  end

  assign active_src = src;

endmodule
